// File: rtl/coherence_bus_ctrl.sv
// Coherence bus responder for two data caches sharing a single-ported RAM.
// Grants one cache at a time, snoops or invalidates the other cache, and
// services one word per grant cycle. A dirty word supplied by the snooped
// cache is forwarded to the requester and written back to RAM.
// Optional build macro: COHERENCE_STATS_EN adds c2c_count / inv_count outputs.
//
// state | meaning
// IDLE  | no owner, arbitrating cctrans requests
// OWN   | bus granted, decoding the owner's next word request
// SNOOP | snoop address presented to the other cache for one cycle
// MEMRD | RAM read on behalf of the owner
// C2C   | snooped cache writes back its dirty word, forwarded to owner
// MEMWR | RAM write from the owner (writeback / flush)
// INVAL | one-cycle invalidate to the other cache (shared-hit upgrade)
module coherence_bus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [1:0]             dREN,
    input  logic [1:0]             dWEN,
    input  logic [1:0][ADDR_W-1:0] daddr,
    input  logic [1:0][DATA_W-1:0] dstore,
    input  logic [1:0]             cctrans,
    input  logic [1:0]             ccwrite,
    output logic [1:0]             dwait,
    output logic [1:0][DATA_W-1:0] dload,
    output logic [1:0]             ccwait,
    output logic [1:0]             ccinv,
    output logic [1:0][ADDR_W-1:0] ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [ADDR_W-1:0]      ramaddr,
    output logic [DATA_W-1:0]      ramstore,
    input  logic [DATA_W-1:0]      ramload,
    input  logic                   ramwait
`ifdef COHERENCE_STATS_EN
    ,
    output logic [31:0]            c2c_count,
    output logic [31:0]            inv_count
`endif
);

    typedef enum logic [2:0] {
        IDLE, OWN, SNOOP, MEMRD, C2C, MEMWR, INVAL
    } state_t;

    state_t     state;
    logic       owner;
    logic       rr_last;
    logic       other;
    logic [1:0] req;
    logic       grant_id;

    assign other = ~owner;
    assign req   = cctrans & ~ccwait;

    // Round-robin pick: a lone requester wins, a tie goes to the cache not granted last.
    always_comb begin
        grant_id = req[1];
        if (req == 2'b11) begin
            grant_id = ~rr_last;
        end
    end

    // Main controller: arbitration, word decode and all registered bus outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            owner       <= 1'b0;
            rr_last     <= 1'b1;
            dwait       <= 2'b11;
            dload       <= '0;
            ccwait      <= 2'b00;
            ccinv       <= 2'b00;
            ccsnoopaddr <= '0;
            ramREN      <= 1'b0;
            ramWEN      <= 1'b0;
            ramaddr     <= '0;
            ramstore    <= '0;
        end else begin
            // completion is a single-cycle pulse
            dwait <= 2'b11;
            if (state == IDLE) begin
                if (|req) begin
                    state   <= OWN;
                    owner   <= grant_id;
                    rr_last <= grant_id;
                end
            end else if (!cctrans[owner]) begin
                // owner released the bus: abandon any word in flight
                state  <= IDLE;
                ramREN <= 1'b0;
                ramWEN <= 1'b0;
                ccwait <= 2'b00;
                ccinv  <= 2'b00;
            end else begin
                case (state)
                    OWN: begin
                        // skip the completion cycle so a still-asserted request is not re-issued
                        if (&dwait) begin
                            if (dWEN[owner]) begin
                                state    <= MEMWR;
                                ramWEN   <= 1'b1;
                                ramaddr  <= daddr[owner];
                                ramstore <= dstore[owner];
                            end else if (dREN[owner]) begin
                                state              <= SNOOP;
                                ccwait[other]      <= 1'b1;
                                ccinv[other]       <= ccwrite[owner];
                                ccsnoopaddr[other] <= daddr[owner];
                            end else if (ccwrite[owner]) begin
                                state              <= INVAL;
                                ccwait[other]      <= 1'b1;
                                ccinv[other]       <= 1'b1;
                                ccsnoopaddr[other] <= daddr[owner];
                            end
                        end
                    end
                    SNOOP: begin
                        if (cctrans[other] && ccwrite[other]) begin
                            state <= C2C;
                        end else begin
                            state   <= MEMRD;
                            ramREN  <= 1'b1;
                            ramaddr <= ccsnoopaddr[other];
                        end
                    end
                    MEMRD: begin
                        if (!ramwait) begin
                            state         <= OWN;
                            ramREN        <= 1'b0;
                            dwait[owner]  <= 1'b0;
                            dload[owner]  <= ramload;
                            ccwait        <= 2'b00;
                            ccinv         <= 2'b00;
                        end
                    end
                    C2C: begin
                        // RAM write starts once the snooped cache presents its dirty word
                        if (ramWEN && !ramwait) begin
                            state        <= OWN;
                            ramWEN       <= 1'b0;
                            dwait        <= 2'b00;
                            dload[owner] <= ramstore;
                            ccwait       <= 2'b00;
                            ccinv        <= 2'b00;
                        end else if (!ramWEN && dWEN[other]) begin
                            ramWEN   <= 1'b1;
                            ramaddr  <= ccsnoopaddr[other];
                            ramstore <= dstore[other];
                        end
                    end
                    MEMWR: begin
                        if (!ramwait) begin
                            state        <= OWN;
                            ramWEN       <= 1'b0;
                            dwait[owner] <= 1'b0;
                        end
                    end
                    INVAL: begin
                        state  <= OWN;
                        ccwait <= 2'b00;
                        ccinv  <= 2'b00;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef COHERENCE_STATS_EN
    logic inv_start;
    logic c2c_done;

    // an invalidating snoop or an upgrade is being launched from OWN this cycle
    assign inv_start = (state == OWN) && cctrans[owner] && (&dwait) &&
                       !dWEN[owner] && ccwrite[owner];
    assign c2c_done  = (state == C2C) && cctrans[owner] && ramWEN && !ramwait;

    // Event counters; free-running, wrap naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (RST) begin
            c2c_count <= '0;
            inv_count <= '0;
        end else begin
            if (c2c_done) begin
                c2c_count <= c2c_count + 32'd1;
            end
            if (inv_start) begin
                inv_count <= inv_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Self-checking bench for coherence_bus_ctrl: two cache agents, a RAM with
// programmable wait states, and a word-level memory/arbitration model.
module tb_coherence_bus_ctrl;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_UPG  = 2;
    localparam int K_RDWR = 3;

    logic              CLK;
    logic              RST;
    logic [1:0]        dREN;
    logic [1:0]        dWEN;
    logic [1:0][31:0]  daddr;
    logic [1:0][31:0]  dstore;
    logic [1:0]        cctrans;
    logic [1:0]        ccwrite;
    logic [1:0]        dwait;
    logic [1:0][31:0]  dload;
    logic [1:0]        ccwait;
    logic [1:0]        ccinv;
    logic [1:0][31:0]  ccsnoopaddr;
    logic              ramREN;
    logic              ramWEN;
    logic [31:0]       ramaddr;
    logic [31:0]       ramstore;
    logic [31:0]       ramload;
    logic              ramwait;
`ifdef COHERENCE_STATS_EN
    logic [31:0]       c2c_count;
    logic [31:0]       inv_count;
    int                exp_c2c;
    int                exp_inv;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // environment and reference state
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    int          ram_lat;
    bit          ram_stuck;
    int          ram_left;
    int          both_cnt;
    int          last_grant;

    coherence_bus_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .dwait       (dwait),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramwait     (ramwait)
`ifdef COHERENCE_STATS_EN
        ,
        .c2c_count   (c2c_count),
        .inv_count   (inv_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // RAM: answers strobes at the negedge, ram_lat wait cycles before each access completes
    initial begin
        ramwait  = 1'b1;
        ramload  = '0;
        ram_left = 0;
        both_cnt = 0;
        ram_mem[32'h100] = 32'hA5;
        forever begin
            @(negedge CLK);
            if (ramREN && ramWEN) both_cnt++;
            if ((ramREN || ramWEN) && !ram_stuck) begin
                if (ram_left > 0) begin
                    ramwait = 1'b1;
                    ram_left--;
                end else begin
                    ramwait = 1'b0;
                    if (ramWEN) ram_mem[ramaddr] = ramstore;
                    else        ramload = ram_rd(ramaddr);
                end
            end else begin
                ramwait  = 1'b1;
                ram_left = ram_lat;
            end
        end
    end

    task automatic release_all();
        cctrans = 2'b00;
        ccwrite = 2'b00;
        dREN    = 2'b00;
        dWEN    = 2'b00;
    endtask

    // One word transaction by cache id on an idle bus; the other cache optionally supplies a dirty word.
    task automatic run_txn(input int id, input int kind, input logic [31:0] addr,
                           input logic [31:0] data, input bit excl, input bit supply,
                           input logic [31:0] sup_data);
        int          o;
        bit          done;
        bit          seen;
        int          first_cyc;
        int          done_cyc;
        int          snoop_cycles;
        int          strobe_cycles;
        logic [31:0] saddr;
        logic        sinv;
        logic [31:0] got_dload;
        logic        got_odw;
        logic [31:0] exp_rd;
        int          lat;
        o = 1 - id;
        done = 0; seen = 0; first_cyc = -1; done_cyc = -1;
        snoop_cycles = 0; strobe_cycles = 0;
        saddr = '0; sinv = 1'b0; got_dload = '0; got_odw = 1'b1;
        lat = ram_lat;
        exp_rd = ref_rd(addr);
        @(negedge CLK);
        daddr[id]   = addr;
        dstore[id]  = data;
        cctrans[id] = 1'b1;
        ccwrite[id] = (kind == K_UPG) || (kind == K_RD && excl);
        dREN[id]    = (kind == K_RD) || (kind == K_RDWR);
        dWEN[id]    = (kind == K_WR) || (kind == K_RDWR);
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge CLK);
            if (ramREN || ramWEN) strobe_cycles++;
            if (ccwait[o]) begin
                snoop_cycles++;
                if (!seen) begin
                    seen = 1; first_cyc = cyc; saddr = ccsnoopaddr[o]; sinv = ccinv[o];
                end
                if (kind == K_UPG) ccwrite[id] = 1'b0;
                if (kind == K_RD && supply) begin
                    cctrans[o] = 1'b1; ccwrite[o] = 1'b1; dWEN[o] = 1'b1;
                    daddr[o] = addr; dstore[o] = sup_data;
                end
            end
            if (kind == K_UPG) begin
                if (seen && !ccwait[o]) done = 1;
            end else if (!dwait[id]) begin
                done = 1; done_cyc = cyc; got_dload = dload[id]; got_odw = dwait[o];
            end
        end
        release_all();
        check_val("txn_done", done, 1);
        last_grant = id;
        case (kind)
            K_RD: begin
                check_val("rd_snoop_seen", seen, 1);
                check_val("rd_snoop_cycle", first_cyc, 1);
                check_val("rd_snoop_addr", saddr, addr);
                check_val("rd_snoop_inv", sinv, excl);
                if (supply) begin
                    check_val("c2c_dload", got_dload, sup_data);
                    check_val("c2c_other_dwait", got_odw, 0);
                    ref_mem[addr] = sup_data;
`ifdef COHERENCE_STATS_EN
                    exp_c2c++;
`endif
                end else begin
                    check_val("rd_dload", got_dload, exp_rd);
                    check_val("rd_latency", done_cyc, 3 + lat);
                end
`ifdef COHERENCE_STATS_EN
                if (excl) exp_inv++;
`endif
            end
            K_WR, K_RDWR: begin
                check_val("wr_no_snoop", snoop_cycles, 0);
                check_val("wr_latency", done_cyc, 2 + lat);
                ref_mem[addr] = data;
            end
            default: begin
                check_val("upg_ccwait_cycles", snoop_cycles, 1);
                check_val("upg_snoop_cycle", first_cyc, 1);
                check_val("upg_snoop_addr", saddr, addr);
                check_val("upg_ccinv", sinv, 1);
                check_val("upg_no_ram", strobe_cycles, 0);
`ifdef COHERENCE_STATS_EN
                exp_inv++;
`endif
            end
        endcase
    endtask

    // Both caches request a write in the same cycle; order must follow round-robin.
    task automatic arb_round(input logic [31:0] a0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [31:0] d1);
        int order[2];
        int n;
        bit act[2];
        int exp_first;
        order[0] = -1; order[1] = -1; n = 0;
        exp_first = (last_grant == 1) ? 0 : 1;
        @(negedge CLK);
        daddr[0] = a0; dstore[0] = d0;
        daddr[1] = a1; dstore[1] = d1;
        cctrans = 2'b11;
        dWEN    = 2'b11;
        act[0] = 1; act[1] = 1;
        for (int cyc = 0; cyc < 200 && n < 2; cyc++) begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (act[i] && !dwait[i]) begin
                    order[n] = i; n++; act[i] = 0;
                    cctrans[i] = 1'b0; dWEN[i] = 1'b0;
                end
            end
        end
        release_all();
        check_val("arb_done", n, 2);
        check_val("arb_first", order[0], exp_first);
        check_val("arb_second", order[1], 1 - exp_first);
        ref_mem[a0] = d0;
        ref_mem[a1] = d1;
        last_grant = 1 - exp_first;
    endtask

    initial begin
        int          id;
        int          r;
        int          kind;
        logic [31:0] addr;
        RST = 1'b1;
        dREN = '0; dWEN = '0; daddr = '0; dstore = '0; cctrans = '0; ccwrite = '0;
        ram_lat = 0; ram_stuck = 0; last_grant = 1;
        ref_mem[32'h100] = 32'hA5;
`ifdef COHERENCE_STATS_EN
        exp_c2c = 0; exp_inv = 0;
`endif
        repeat (3) @(negedge CLK);
        check_val("rst_dwait", dwait, 2'b11);
        check_val("rst_ccwait", ccwait, 0);
        check_val("rst_ccinv", ccinv, 0);
        check_val("rst_ram_strobes", {ramREN, ramWEN}, 0);
        check_val("rst_ramaddr", ramaddr, 0);
        check_val("rst_ramstore", ramstore, 0);
        check_val("rst_dload0", dload[0], 0);
        check_val("rst_dload1", dload[1], 0);
        check_val("rst_snoopaddr0", ccsnoopaddr[0], 0);
        check_val("rst_snoopaddr1", ccsnoopaddr[1], 0);
        RST = 1'b0;

        // arbitration after reset and alternation on repeated ties
        arb_round(32'h500, 32'h11, 32'h504, 32'h22);
        arb_round(32'h508, 32'h33, 32'h50C, 32'h44);

        // directed scenarios
        ram_lat = 2;
        run_txn(0, K_RD, 32'h100, 32'h0, 0, 0, 32'h0);
        ram_lat = 1;
        run_txn(0, K_RD, 32'h200, 32'h0, 1, 1, 32'hBEEF);
        check_val("c2c_ram_0x200", ram_rd(32'h200), 32'hBEEF);
        run_txn(1, K_UPG, 32'h40, 32'h0, 0, 0, 32'h0);
        ram_lat = 0;
        run_txn(0, K_WR, 32'h3100, 32'h7, 0, 0, 32'h0);
        check_val("wr_ram_0x3100", ram_rd(32'h3100), 32'h7);
`ifdef COHERENCE_STATS_EN
        check_val("stats_c2c", c2c_count, exp_c2c);
        check_val("stats_inv", inv_count, exp_inv);
`endif

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            if (t % 10 == 9) begin
                arb_round(32'h2000 + 32'($urandom_range(0, 7)) * 4, $urandom,
                          32'h3000 + 32'($urandom_range(0, 7)) * 4, $urandom);
            end else begin
                id   = $urandom_range(0, 1);
                r    = $urandom_range(0, 99);
                kind = (r < 45) ? K_RD : (r < 75) ? K_WR : (r < 90) ? K_UPG : K_RDWR;
                addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
                ram_lat = $urandom_range(0, 3);
                run_txn(id, kind, addr, $urandom, 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 2) == 0), $urandom);
            end
        end
`ifdef COHERENCE_STATS_EN
        check_val("stats_c2c_rand", c2c_count, exp_c2c);
        check_val("stats_inv_rand", inv_count, exp_inv);
`endif

        // RAM stuck busy: controller waits indefinitely, then reset aborts the read
        ram_stuck = 1;
        @(negedge CLK);
        daddr[0] = 32'h1234; cctrans[0] = 1'b1; dREN[0] = 1'b1;
        repeat (20) @(negedge CLK);
        check_val("stuck_ramREN", ramREN, 1);
        check_val("stuck_dwait", dwait, 2'b11);
        check_val("stuck_ccwait1", ccwait[1], 1);
        RST = 1'b1;
        @(negedge CLK);
        check_val("midrst_strobes", {ramREN, ramWEN}, 0);
        check_val("midrst_dwait", dwait, 2'b11);
        check_val("midrst_ccwait", ccwait, 0);
        check_val("midrst_ccinv", ccinv, 0);
        check_val("midrst_snoopaddr1", ccsnoopaddr[1], 0);
`ifdef COHERENCE_STATS_EN
        check_val("midrst_c2c", c2c_count, 0);
        check_val("midrst_inv", inv_count, 0);
`endif
        release_all();
        ram_stuck = 0;
        @(negedge CLK);
        RST = 1'b0;
        last_grant = 1;

        // recovery after reset, then a final tie must again favour cache 0
        ram_lat = 1;
        run_txn(1, K_RD, 32'h100, 32'h0, 0, 0, 32'h0);
        last_grant = 1;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        arb_round(32'h600, 32'h55, 32'h604, 32'h66);

        // memory image must match the model everywhere the model was touched
        foreach (ref_mem[k]) begin
            check_val("mem_image", ram_rd(k), ref_mem[k]);
        end
        check_val("ram_rd_wr_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
